atm_module: RTL and testbench

- Single-session ATM transaction controller.
- A card number starts a session, which then runs PIN check, language selection, and one or two banking services (inquiry, deposit, withdraw) against an 8-bit account balance.
- The account record (correctPin, currentbalance) is supplied by the surrounding account store.
- The block reports the updated balance, a session-active flag and a timeout flag.

---
 rtl/atm_pkg.sv | 28 ++
 rtl/atm_txn_alu.sv | 35 +++
 rtl/atm_module.sv | 128 ++++++++++++
 tb/tb_atm_module.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and widths for the ATM transaction controller.
// Imported by the ALU and the top-level FSM.
package atm_pkg;

  localparam int CARD_W = 8;
  localparam int PIN_W  = 4;
  localparam int BAL_W  = 8;
  localparam int AMT_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK_PIN,
    LANG,
    SERVICE,
    EXEC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SVC_INQ  = 2'b00,
    SVC_DEP  = 2'b01,
    SVC_WDR  = 2'b10,
    SVC_EXIT = 2'b11
  } svc_t;

  localparam logic [1:0] LANG_NONE = 2'b00;

endpackage

// File: rtl/atm_txn_alu.sv
// Combinational balance update for one banking service.
// Rejects deposits that overflow and withdrawals that underflow.
module atm_txn_alu
  import atm_pkg::*;
(
  input  logic [BAL_W-1:0] work,
  input  logic [AMT_W-1:0] amount,
  input  svc_t             service,
  output logic [BAL_W-1:0] next_work,
  output logic             reject
);

  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] amt_ext;

  // Apply the selected service; a rejected step leaves work untouched
  always_comb begin
    amt_ext   = {{(BAL_W-AMT_W){1'b0}}, amount};
    sum       = {1'b0, work} + {1'b0, amt_ext};
    next_work = work;
    reject    = 1'b0;
    case (service)
      SVC_DEP: begin
        if (sum[BAL_W]) reject = 1'b1;
        else next_work = sum[BAL_W-1:0];
      end
      SVC_WDR: begin
        if (amt_ext > work) reject = 1'b1;
        else next_work = work - amt_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/atm_module.sv
// Single-session ATM controller: PIN check, language, one or two
// services on a working balance, committed to balance in DONE.
module atm_module
  import atm_pkg::*;
#(
  parameter int TIMEOUT      = 10,
  parameter int MAX_SERVICES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CARD_W-1:0] cardno,
  input  logic [PIN_W-1:0]  pin,
  input  logic [PIN_W-1:0]  correctPin,
  input  logic [BAL_W-1:0]  currentbalance,
  input  logic [1:0]        language,
  input  logic [1:0]        service,
  input  logic [AMT_W-1:0]  amount,
  input  logic              anotherServiceBit,
  output logic [BAL_W-1:0]  balance,
  output logic              amIhere,
  output logic              longTime
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(MAX_SERVICES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_SERVICES);

  state_t           state, state_nx;
  logic [BAL_W-1:0] work, alu_work;
  logic [CW-1:0]    svc_cnt, svc_cnt_nx;
  logic [TW-1:0]    timer;
  svc_t             svc_q;
  logic [AMT_W-1:0] amt_q;
  logic             alu_rej;
  logic             card_on, lang_idle, more;
  logic             start, tick, expire;
  logic             capture, exec_en, commit;

  assign card_on    = (cardno != '0);
  assign lang_idle  = (language == LANG_NONE);
  assign svc_cnt_nx = svc_cnt + CW'(1);
  assign more       = anotherServiceBit && (svc_cnt_nx < C_MAX);

  atm_txn_alu u_alu (
    .work      (work),
    .amount    (amt_q),
    .service   (svc_q),
    .next_work (alu_work),
    .reject    (alu_rej)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; a removed card aborts any active session
  always_comb begin
    state_nx = state;
    if (state != IDLE && !card_on) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      if (card_on) state_nx = CHECK_PIN;
        CHECK_PIN: state_nx = (pin == correctPin) ? LANG : IDLE;
        LANG: begin
          if (!lang_idle)           state_nx = SERVICE;
          else if (timer == T_LAST) state_nx = IDLE;
        end
        SERVICE:   state_nx = EXEC;
        EXEC: begin
          if (svc_q == SVC_EXIT) state_nx = DONE;
          else if (more)         state_nx = SERVICE;
          else                   state_nx = DONE;
        end
        DONE:      state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // Outputs and datapath strobes decoded from state
  always_comb begin
    amIhere = (state != IDLE);
    start   = (state == IDLE) && card_on;
    tick    = (state == LANG) && card_on && lang_idle;
    expire  = tick && (timer == T_LAST);
    capture = (state == SERVICE) && card_on;
    exec_en = (state == EXEC) && card_on;
    commit  = (state == DONE) && card_on;
  end

  // Session datapath: working balance, counters, captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      svc_cnt  <= '0;
      timer    <= '0;
      svc_q    <= SVC_INQ;
      amt_q    <= '0;
      balance  <= '0;
      longTime <= 1'b0;
    end else begin
      if (start) begin
        work     <= currentbalance;
        svc_cnt  <= '0;
        timer    <= '0;
        longTime <= 1'b0;
      end
      if (tick) begin
        if (expire) longTime <= 1'b1;
        else        timer    <= timer + TW'(1);
      end
      if (capture) begin
        svc_q <= svc_t'(service);
        amt_q <= amount;
      end
      if (exec_en) begin
        if (!alu_rej) work <= alu_work;
        svc_cnt <= svc_cnt_nx;
      end
      if (commit) balance <= work;
    end
  end

endmodule

// File: tb/tb_atm_module.sv
// Directed bench for atm_module: vector table of full sessions
// plus hand sequences for PIN, timeout, abort and reset cases.
module tb_atm_module;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cardno;
  logic [3:0] pin, correctPin;
  logic [7:0] currentbalance;
  logic [1:0] language, service;
  logic [4:0] amount;
  logic       anotherServiceBit;
  logic [7:0] balance;
  logic       amIhere, longTime;

  int n_cmp = 0;
  int n_bad = 0;
  int prev  = 0;

  typedef struct {
    logic [7:0] cb;
    logic [1:0] svc;
    logic [4:0] amt;
    logic       another;
    logic [7:0] exp;
    int         edges;
  } vec_t;

  vec_t vecs [10];

  atm_module dut (
    .clk               (clk),
    .rst               (rst),
    .cardno            (cardno),
    .pin               (pin),
    .correctPin        (correctPin),
    .currentbalance    (currentbalance),
    .language          (language),
    .service           (service),
    .amount            (amount),
    .anotherServiceBit (anotherServiceBit),
    .balance           (balance),
    .amIhere           (amIhere),
    .longTime          (longTime)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [7:0] cb, input logic [1:0] svc,
                       input logic [4:0] amt, input logic another);
    currentbalance    = cb;
    service           = svc;
    amount            = amt;
    anotherServiceBit = another;
    language          = 2'b01;
    pin               = 4'b1010;
    correctPin        = 4'b1010;
  endtask

  task automatic run(input string name, input vec_t v);
    setup(v.cb, v.svc, v.amt, v.another);
    cardno = 8'h21;
    step(1);
    check({name, "_active"}, amIhere, 1);
    step(v.edges - 2);
    check({name, "_hold"}, balance, prev);
    step(1);
    check({name, "_bal"}, balance, v.exp);
    check({name, "_idle"}, amIhere, 0);
    cardno = 8'h00;
    prev = v.exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd100, 2'b01, 5'd20, 1'b0, 8'd120, 6};
    vecs[1] = '{8'd50,  2'b10, 5'd10, 1'b1, 8'd30,  8};
    vecs[2] = '{8'd250, 2'b01, 5'd10, 1'b0, 8'd250, 6};
    vecs[3] = '{8'd5,   2'b10, 5'd6,  1'b0, 8'd5,   6};
    vecs[4] = '{8'd224, 2'b01, 5'd31, 1'b0, 8'd255, 6};
    vecs[5] = '{8'd200, 2'b00, 5'd7,  1'b0, 8'd200, 6};
    vecs[6] = '{8'd100, 2'b01, 5'd31, 1'b1, 8'd162, 8};
    vecs[7] = '{8'd240, 2'b01, 5'd10, 1'b1, 8'd250, 8};
    vecs[8] = '{8'd15,  2'b10, 5'd10, 1'b1, 8'd5,   8};
    vecs[9] = '{8'd77,  2'b11, 5'd3,  1'b1, 8'd77,  6};

    rst    = 1'b1;
    cardno = 8'h00;
    setup(8'd0, 2'b00, 5'd0, 1'b0);
    #12;
    check("rst_bal", balance, 0);
    check("rst_here", amIhere, 0);
    check("rst_long", longTime, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), vecs[i]);

    // Held inputs: back-to-back sessions recompute, never accumulate
    setup(8'd100, 2'b01, 5'd20, 1'b0);
    cardno = 8'h21;
    step(6);
    check("lvl_first", balance, 120);
    step(1);
    check("lvl_restart", amIhere, 1);
    step(6);
    check("lvl_second", balance, 120);
    cardno = 8'h00;
    prev = 120;
    step(1);

    // Wrong PIN: one cycle in CHECK_PIN, balance untouched
    setup(8'd9, 2'b01, 5'd1, 1'b0);
    pin = 4'b0011;
    cardno = 8'h21;
    step(1);
    check("pin_here", amIhere, 1);
    step(1);
    check("pin_drop", amIhere, 0);
    cardno = 8'h00;
    check("pin_bal", balance, prev);
    step(1);

    // Timeout: LANG entered at edge 2, aborts at edge 12
    setup(8'd9, 2'b01, 5'd1, 1'b0);
    language = 2'b00;
    cardno = 8'h21;
    step(11);
    check("to_before", longTime, 0);
    check("to_here", amIhere, 1);
    step(1);
    check("to_long", longTime, 1);
    check("to_idle", amIhere, 0);
    check("to_bal", balance, prev);
    cardno = 8'h00;
    step(2);
    check("to_sticky", longTime, 1);
    setup(8'd10, 2'b01, 5'd1, 1'b0);
    cardno = 8'h21;
    step(1);
    check("to_clear", longTime, 0);
    step(5);
    check("to_next", balance, 11);
    cardno = 8'h00;
    prev = 11;
    step(1);

    // Card removed while in SERVICE
    setup(8'd100, 2'b01, 5'd20, 1'b0);
    cardno = 8'h21;
    step(3);
    cardno = 8'h00;
    step(1);
    check("abort_idle", amIhere, 0);
    step(4);
    check("abort_bal", balance, prev);

    // Reset while in EXEC
    setup(8'd100, 2'b01, 5'd20, 1'b0);
    cardno = 8'h21;
    step(4);
    check("mid_here", amIhere, 1);
    rst = 1'b1;
    #1;
    check("mid_bal", balance, 0);
    check("mid_here0", amIhere, 0);
    check("mid_long", longTime, 0);
    cardno = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    step(2);
    check("post_rst", amIhere, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
